// File: rtl/melody_pkg.sv
// melody_pkg: note codes, frequency lookup, FSM states and the song table for melody_sequencer
package melody_pkg;

    typedef logic [3:0] note_t;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    localparam logic [31:0] SIL = 32'd50_000_000;

    localparam int SONG_MAX = 32;
    localparam int TABLE_CH = 2;

    // Beats beyond SONG_MAX or channels beyond TABLE_CH play silence
    localparam note_t SONG_TABLE [SONG_MAX][TABLE_CH] = '{
        '{4'd9, 4'd4}, '{4'd9, 4'd0}, '{4'd0, 4'd4}, '{4'd6, 4'd8},
        '{4'd5, 4'd1}, '{4'd5, 4'd0}, '{4'd4, 4'd1}, '{4'd0, 4'd2},
        '{4'd8, 4'd3}, '{4'd8, 4'd0}, '{4'd7, 4'd3}, '{4'd6, 4'd0},
        '{4'd5, 4'd2}, '{4'd0, 4'd2}, '{4'd4, 4'd0}, '{4'd4, 4'd1},
        '{4'd9, 4'd4}, '{4'd8, 4'd0}, '{4'd7, 4'd4}, '{4'd6, 4'd8},
        '{4'd5, 4'd1}, '{4'd4, 4'd0}, '{4'd3, 4'd1}, '{4'd0, 4'd2},
        '{4'd2, 4'd3}, '{4'd3, 4'd0}, '{4'd4, 4'd3}, '{4'd5, 4'd0},
        '{4'd6, 4'd2}, '{4'd8, 4'd2}, '{4'd9, 4'd0}, '{4'd0, 4'd0}
    };

    // Codes 0 and 10..15 are silence; SIL is recognised downstream as "do not shift"
    function automatic logic [31:0] note_freq(input note_t n);
        case (n)
            4'd1:    return 32'd262;
            4'd2:    return 32'd392;
            4'd3:    return 32'd494;
            4'd4:    return 32'd524;
            4'd5:    return 32'd588;
            4'd6:    return 32'd660;
            4'd7:    return 32'd698;
            4'd8:    return 32'd784;
            4'd9:    return 32'd988;
            default: return SIL;
        endcase
    endfunction

endpackage

// File: rtl/melody_sequencer_note_rom.sv
// note_rom: combinational song table lookup from beat index and channel to note code
module note_rom
    import melody_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int BEAT_W   = 12
) (
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [7:0]        ch_i,
    output note_t             code_o
);

    // Compare chain keeps the lookup width-safe for any BEAT_W
    always_comb begin
        code_o = 4'd0;
        for (int b = 0; b < SONG_MAX; b++)
            for (int c = 0; c < TABLE_CH; c++)
                if (b < SONG_LEN && int'(beat_i) == b && int'(ch_i) == c)
                    code_o = SONG_TABLE[b][c];
    end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: tempo-divided song player driving one registered tone frequency per channel
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BEAT_HZ  = 16,
    parameter int NUM_CH   = 2,
    parameter int SONG_LEN = 32,
    parameter int BEAT_W   = 12,
    parameter int TONE_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop_en,
    input  logic [1:0]               oct_shift,
    output logic [NUM_CH*TONE_W-1:0] tone,
    output logic [BEAT_W-1:0]        beat_num,
    output logic                     busy,
    output logic                     done
);

    localparam int TICK  = (CLK_HZ / BEAT_HZ < 1) ? 1 : CLK_HZ / BEAT_HZ;
    localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SONG_LEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                busy_q, done_q, done_d;
    logic [NUM_CH*TONE_W-1:0] tone_q;
    logic [TONE_W-1:0]   tone_d [NUM_CH];
    logic                step, song_end;

    assign step     = (state_q == PLAY) && (cnt_q == CNT_LAST);
    assign song_end = step && (beat_q == BEAT_LAST) && !loop_en;

    // Next state, tick divider and beat counter; stop beats start beats pause
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            beat_d  = '0;
        end else if (start) begin
            state_d = PLAY;
            cnt_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    cnt_d   = step ? '0 : cnt_q + CNT_W'(1);
                    state_d = pause ? PAUSE : PLAY;
                    if (song_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (step)
                        beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
                end
                PAUSE:   state_d = pause ? PAUSE : PLAY;
                default: cnt_d = '0;
            endcase
        end
    end

    // Tones follow the next beat so tone and beat_num change on the same edge
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        note_t       code;
        logic [31:0] freq;
        note_rom #(.SONG_LEN(SONG_LEN), .BEAT_W(BEAT_W)) u_rom (
            .beat_i (beat_d),
            .ch_i   (8'(c)),
            .code_o (code)
        );
        assign freq      = note_freq(code);
        assign tone_d[c] = (state_d == PLAY && freq != SIL) ? TONE_W'(freq << oct_shift) : TONE_W'(SIL);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                tone_q[c*TONE_W +: TONE_W] <= TONE_W'(SIL);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            for (int c = 0; c < NUM_CH; c++)
                tone_q[c*TONE_W +: TONE_W] <= tone_d[c];
        end
    end

    assign tone     = tone_q;
    assign beat_num = beat_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
